mem_port_arb: RTL and testbench

Round-robin arbiter that shares the single read/write port (port B) of the on-chip data RAM between two requesters, e.g. the scalar load/store unit and the vector memory unit. It accepts at most one access per cycle, drives the RAM port-B address, write-enable and write data, and routes the RAM's one-cycle-latency read data back to the requester that issued the read. An optional lock mechanism lets one requester own the port for a bounded burst.

---
 rtl/mem_port_arb.sv | 140 ++++++++++++++
 tb/tb_mem_port_arb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// mem_port_arb: round-robin arbiter sharing RAM port B between two requesters; lock bursts built with MEM_ARB_LOCK_EN
module mem_port_arb #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_0,
  input  logic                  i_we_0,
  input  logic                  i_lock_0,
  input  logic [ADDR_WIDTH-1:0] i_addr_0,
  input  logic [DATA_WIDTH-1:0] i_wdata_0,
  output logic                  o_gnt_0,
  output logic                  o_rvalid_0,
  output logic [DATA_WIDTH-1:0] o_rdata_0,
  input  logic                  i_req_1,
  input  logic                  i_we_1,
  input  logic                  i_lock_1,
  input  logic [ADDR_WIDTH-1:0] i_addr_1,
  input  logic [DATA_WIDTH-1:0] i_wdata_1,
  output logic                  o_gnt_1,
  output logic                  o_rvalid_1,
  output logic [DATA_WIDTH-1:0] o_rdata_1,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t                  w_state;
  logic                    r_prio;
  logic                    r_rvalid_0;
  logic                    r_rvalid_1;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_din;
  logic                    w_gnt_0;
  logic                    w_gnt_1;
  logic                    w_any;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_din;
  logic                    w_sel_we;

  // Grant selection: an owner excludes the other side, otherwise lone requester or prio wins; reset blocks all grants
  always_comb begin
    w_gnt_0 = 1'b0;
    w_gnt_1 = 1'b0;
    if (!rst) begin
      if (w_state == OWN0) w_gnt_0 = i_req_0;
      else if (w_state == OWN1) w_gnt_1 = i_req_1;
      else begin
        w_gnt_0 = i_req_0 & (~i_req_1 | ~r_prio);
        w_gnt_1 = i_req_1 & (~i_req_0 |  r_prio);
      end
    end
  end

  assign w_any      = w_gnt_0 | w_gnt_1;
  assign w_sel_addr = w_gnt_1 ? i_addr_1  : i_addr_0;
  assign w_sel_din  = w_gnt_1 ? i_wdata_1 : i_wdata_0;
  assign w_sel_we   = w_gnt_1 ? i_we_1    : i_we_0;

  assign o_gnt_0    = w_gnt_0;
  assign o_gnt_1    = w_gnt_1;
  assign o_ram_we   = w_any & w_sel_we;
  assign o_ram_addr = w_any ? w_sel_addr : r_addr;
  assign o_ram_din  = w_any ? w_sel_din  : r_din;
  assign o_rvalid_0 = r_rvalid_0;
  assign o_rvalid_1 = r_rvalid_1;
  assign o_rdata_0  = i_ram_dout;
  assign o_rdata_1  = i_ram_dout;

  // Priority flips to the loser of each grant; port-B fields are held between grants; reads answer one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio     <= 1'b0;
      r_rvalid_0 <= 1'b0;
      r_rvalid_1 <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      r_rvalid_0 <= w_gnt_0 & ~i_we_0;
      r_rvalid_1 <= w_gnt_1 & ~i_we_1;
      if (w_any) begin
        r_prio <= w_gnt_0;
        r_addr <= w_sel_addr;
        r_din  <= w_sel_din;
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] MAX_CNT = LW'(MAX_LOCK);
  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_lock_cnt;
  logic [LW-1:0]   w_lock_cnt_nxt;
  logic [LW-1:0]   w_cnt_inc;
  logic            w_own_req;
  logic            w_own_lock;

  assign w_state    = r_state;
  assign w_cnt_inc  = r_lock_cnt + 1'b1;
  assign w_own_req  = (r_state == OWN0) ? i_req_0  : i_req_1;
  assign w_own_lock = (r_state == OWN0) ? i_lock_0 : i_lock_1;

  // Ownership state and burst counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Enter ownership on a locked grant; leave on drop of req, drop of lock, or reaching the burst limit
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    if (r_state == IDLE) begin
      if ((w_gnt_0 & i_lock_0) | (w_gnt_1 & i_lock_1)) begin
        w_state_nxt    = (MAX_LOCK == 1) ? IDLE : (w_gnt_0 ? OWN0 : OWN1);
        w_lock_cnt_nxt = (MAX_LOCK == 1) ? '0 : LW'(1);
      end
    end else if (!w_own_req || !w_own_lock || w_cnt_inc == MAX_CNT) begin
      w_state_nxt    = IDLE;
      w_lock_cnt_nxt = '0;
    end else begin
      w_lock_cnt_nxt = w_cnt_inc;
    end
  end
`else
  logic w_unused_lock;
  assign w_state       = IDLE;
  assign w_unused_lock = i_lock_0 | i_lock_1 | (MAX_LOCK < 1);
`endif
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: randomized and directed checks of mem_port_arb against a cycle-level reference model
module tb_mem_port_arb;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req   [2];
  logic          we    [2];
  logic          lock  [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          o_gnt_0, o_gnt_1, o_rvalid_0, o_rvalid_1, o_ram_we;
  logic [DW-1:0] o_rdata_0, o_rdata_1, o_ram_din;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] ram [16] = '{default: '0};

  int            n_cmp = 0;
  int            n_bad = 0;
  int            prio_m = 0;
  int            owner_m = -1;
  int            beats_m = 0;
  int            last_w = -1;
  logic          exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  logic [AW-1:0] addr_h = '0;
  logic [DW-1:0] din_h = '0;
  logic [DW-1:0] ref_mem [16] = '{default: '0};

  mem_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .i_req_0(req[0]), .i_we_0(we[0]), .i_lock_0(lock[0]), .i_addr_0(addr[0]), .i_wdata_0(wdata[0]),
    .o_gnt_0(o_gnt_0), .o_rvalid_0(o_rvalid_0), .o_rdata_0(o_rdata_0),
    .i_req_1(req[1]), .i_we_1(we[1]), .i_lock_1(lock[1]), .i_addr_1(addr[1]), .i_wdata_1(wdata[1]),
    .o_gnt_1(o_gnt_1), .o_rvalid_1(o_rvalid_1), .o_rdata_1(o_rdata_1),
    .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .i_ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_ram_we) ram[o_ram_addr] <= o_ram_din;
    ram_dout <= ram[o_ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set(input int i, input logic r, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r; we[i] = w; lock[i] = l; addr[i] = a; wdata[i] = d;
  endtask

  task automatic model_reset();
    prio_m = 0; owner_m = -1; beats_m = 0;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    addr_h = '0; din_h = '0;
  endtask

  task automatic step();
    int w;
    logic ewe;
    #1;
    w = -1;
    if (!rst) begin
      if (owner_m >= 0) w = req[owner_m] ? owner_m : -1;
      else if (req[0] && req[1]) w = prio_m;
      else if (req[0]) w = 0;
      else if (req[1]) w = 1;
    end
    ewe = (w >= 0) ? we[w] : 1'b0;
    chk("gnt0", o_gnt_0, w == 0);
    chk("gnt1", o_gnt_1, w == 1);
    chk("ram_we", o_ram_we, ewe);
    chk("ram_addr", o_ram_addr, (w >= 0) ? addr[w] : addr_h);
    chk("ram_din", o_ram_din, (w >= 0) ? wdata[w] : din_h);
    chk("rvalid0", o_rvalid_0, exp_rv[0]);
    chk("rvalid1", o_rvalid_1, exp_rv[1]);
    if (exp_rv[0]) chk("rdata0", o_rdata_0, exp_rd[0]);
    if (exp_rv[1]) chk("rdata1", o_rdata_1, exp_rd[1]);
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    if (w >= 0) begin
      prio_m = 1 - w;
      addr_h = addr[w];
      din_h  = wdata[w];
      if (we[w]) ref_mem[addr[w]] = wdata[w];
      else begin
        exp_rv[w] = 1'b1;
        exp_rd[w] = ref_mem[addr[w]];
      end
    end
`ifdef MEM_ARB_LOCK_EN
    if (owner_m >= 0) begin
      if (w < 0) owner_m = -1;
      else begin
        beats_m++;
        if (!lock[w] || beats_m == ML) owner_m = -1;
      end
    end else if (w >= 0 && lock[w]) begin
      owner_m = w;
      beats_m = 1;
      if (beats_m == ML) owner_m = -1;
    end
`endif
    last_w = w;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    set(0, 1, 1, 0, 4'd3, 32'h55);
    set(1, 1, 0, 0, 4'd7, 32'h66);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    // write then read, requester 0 only
    set(1, 0, 0, 0, 0, 0);
    set(0, 1, 1, 0, 4'd5, 32'h1234);
    step();
    set(0, 1, 0, 0, 4'd5, 0);
    step();
    set(0, 0, 0, 0, 0, 0);
    step();
    // preload then simultaneous reads
    set(0, 1, 1, 0, 4'd1, 32'hA);
    step();
    set(0, 0, 0, 0, 0, 0);
    set(1, 1, 1, 0, 4'd2, 32'hB);
    step();
    set(0, 1, 0, 0, 4'd1, 0);
    set(1, 1, 0, 0, 4'd2, 0);
    step();
    if (last_w >= 0) req[last_w] = 1'b0;
    step();
    set(0, 0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0, 0);
    step();
    // sustained contention
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 2; i++) set(i, 1, 1'($urandom % 2), 0, 4'($urandom), $urandom);
      step();
    end
    // locked bursts from requester 0 against a busy requester 1
    for (int c = 0; c < 8; c++) begin
      set(0, 1, 1'($urandom % 2), 1, 4'($urandom), $urandom);
      set(1, 1, 1'($urandom % 2), 0, 4'($urandom), $urandom);
      step();
    end
    // randomized traffic with requests held until granted
    set(0, 0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++)
        if (!req[i] && ($urandom % 10) < 6)
          set(i, 1, 1'($urandom % 2), 1'(($urandom % 4) != 0), 4'($urandom), $urandom);
      step();
      if (last_w >= 0) req[last_w] = 1'b0;
    end
    // reset in the cycle after a read grant
    set(0, 0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0, 0);
    step();
    set(0, 1, 0, 0, 4'd5, 0);
    step();
    chk("rv_before_rst", o_rvalid_0, exp_rv[0]);
    rst = 1'b1;
    #1;
    chk("rv_drop_on_rst", o_rvalid_0, 1'b0);
    model_reset();
    set(1, 1, 0, 0, 4'd2, 0);
    step();
    rst = 1'b0;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
